// File: rtl/seg7_scan_driver_if.sv
// Pin-side bundle for the two-digit seven-segment scan driver.
// master = byte source / board wrapper, slave = the driver.
interface seg7_scan_driver_if;
  logic [7:0] value;
  logic [1:0] dp_in;
  logic       load;
  logic       blank_in;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig_en;
  logic       frame_done;

  modport master (output value, dp_in, load, blank_in,
                  input  seg, dp, dig_en, frame_done);
  modport slave  (input  value, dp_in, load, blank_in,
                  output seg, dp, dig_en, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed hex display driver with blanking gaps and frame-boundary commit.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens a zero upper digit that has no decimal point.
module seg7_scan_driver #(
  parameter int SHOW_CYCLES  = 8192,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    shadow_q, shadow_d, disp_q, disp_d;   // {dp[1:0], value[7:0]}
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    en_q, en_d;
  logic          fd_q;
  logic          last, commit, dark, nib_dp;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    last    = (state_q == SHOW0 || state_q == SHOW1) ? (cnt_q == SHOW_LAST)
                                                     : (cnt_q == BLANK_LAST);
    if (last) begin
      cnt_d = '0;
      case (state_q)
        BLANK0:  state_d = SHOW0;
        SHOW0:   state_d = BLANK1;
        BLANK1:  state_d = SHOW1;
        default: state_d = BLANK0;
      endcase
    end
    commit = last && (state_q == SHOW1);

    // A load on the commit edge lands in the shadow first, so it also bypasses into disp.
    shadow_d = bus.load ? {bus.dp_in, bus.value} : shadow_q;
    disp_d   = commit ? shadow_d : disp_q;

    // Outputs are computed from the next state so they switch on the same edge.
    nib    = (state_d == SHOW1) ? disp_d[7:4] : disp_d[3:0];
    nib_dp = (state_d == SHOW1) ? disp_d[9]   : disp_d[8];
    dark   = bus.blank_in || (state_d == BLANK0) || (state_d == BLANK1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (state_d == SHOW1 && nib == 4'h0 && !nib_dp) dark = 1'b1;
`endif
    en_d  = dark ? 2'b00 : ((state_d == SHOW0) ? 2'b01 : 2'b10);
    seg_d = dark ? 7'h00 : hex7(nib);
    dp_d  = dark ? 1'b0  : nib_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BLANK0;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      en_q     <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      fd_q     <= commit;
    end
  end

  assign bus.seg        = seg_q ^ {7{ACTIVE_LOW}};
  assign bus.dp         = dp_q ^ ACTIVE_LOW;
  assign bus.dig_en     = en_q ^ {2{ACTIVE_LOW}};
  assign bus.frame_done = fd_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the VSLC core's 8-bit output byte on the board wrapper.
- Drives the dual-digit multiplexed seven-segment Pmod.
- Latches a byte on a load strobe and shows it as two hex digits, scanned alternately, with a blanking gap between digit switches to prevent ghosting.
- New values are committed only at frame boundaries, so a frame never mixes old and new nibbles.

Parameters:
- SHOW_CYCLES, 8192, clk cycles each digit is lit per frame; must be >= 1.
- BLANK_CYCLES, 16, clk cycles all digits are dark before each digit; must be >= 1.
- ACTIVE_LOW, 0, 1 inverts seg, dp and dig_en at the pins (inactive = 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value  input  8  byte to display; [3:0] goes to digit 0, [7:4] to digit 1.
- dp_in  input  2  decimal points; bit i belongs to digit i.
- load  input  1  single-cycle strobe; captures value and dp_in into the shadow register.
- blank_in  input  1  forces the display dark while high.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.
- dig_en  output  2  digit enables, one-hot or zero; bit0 = digit 0.
- frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset is asynchronous; it is fixed as stated above. While rst_n is low:
  - seg, dp and dig_en are inactive (0, or all-ones when ACTIVE_LOW=1).
  - frame_done = 0.
  - State = BLANK0, cycle counter = 0.
  - Shadow and display registers = 0.
- The same reset applies mid-operation: the frame aborts immediately, and scanning restarts in BLANK0 after release.
- State machine: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
  - Each BLANKx state lasts BLANK_CYCLES cycles; each SHOWx state lasts SHOW_CYCLES cycles.
  - The counter is sized clog2(max(SHOW_CYCLES, BLANK_CYCLES)+1). It resets to 0 on every state change.
- Outputs are registered and change on the same edge as the state:
  - In BLANKx: dig_en = 00, seg and dp inactive.
  - In SHOW0: dig_en = 01, seg = decode(disp[3:0]), dp = disp_dp[0].
  - In SHOW1: dig_en = 10, seg = decode(disp[7:4]), dp = disp_dp[1].
- Frame period is 2*(SHOW_CYCLES+BLANK_CYCLES) cycles.
- Hex decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Load: on a clk edge with load=1, the shadow register takes {dp_in, value}. Multiple loads within one frame: the last one wins.
- Commit (SHOW1 -> BLANK0 edge):
  - The display register takes the shadow.
  - frame_done is high for exactly the following cycle.
  - If load is also high on that edge, the display register takes the incoming {dp_in, value} directly (bypass), and the shadow takes it too.
- blank_in = 1:
  - Forces dig_en, seg and dp inactive from the next edge.
  - The state machine, counter, loads, commits and frame_done continue unaffected.
  - After blank_in falls, outputs resume on the next edge according to the current state.
- ACTIVE_LOW is applied as a final inversion on seg, dp and dig_en only. frame_done is always active-high.
- The block never asserts both dig_en bits at once.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - In SHOW1, if disp[7:4] == 0 and disp_dp[1] == 0, then dig_en, seg and dp are inactive for the whole SHOW1 period.
  - Timing, the counter and frame_done are unchanged.
- When undefined: digit 1 always shows, including "0".

Test Plan:
- Reset and first commit (SHOW_CYCLES=4, BLANK_CYCLES=2):
  - Stimulus: hold rst_n low, then release; load value=A5, dp_in=00.
  - Before any load, outputs are inactive except that zeros display after the first commit; dig_en=00 for the first 2 cycles after release.
  - Once A5 is committed: dig_en=01 with seg=6D for 4 cycles, 00 for 2, 10 with seg=77 for 4; frame_done pulses every 12 cycles.
- No tearing:
  - Stimulus: pulse load with 3C in the middle of SHOW0 while 12 is displayed.
  - Required: SHOW1 still shows 1 (06); the next frame shows C (39) then 3 (4F).
- Coincident load and commit:
  - Stimulus: load 7E exactly on the SHOW1 -> BLANK0 edge.
  - Required: the next SHOW0 shows E (79) and SHOW1 shows 7 (07).
- blank_in:
  - Stimulus: raise blank_in for 5 cycles mid-SHOW0.
  - Required: dig_en=00 and seg=00 from the next edge; frame_done timing unchanged; display resumes in-phase.
- ACTIVE_LOW=1:
  - Stimulus: value 08, dp_in=01.
  - Required: SHOW0 gives seg=00, dp=0, dig_en=10; blank periods give seg=7F, dp=1, dig_en=11.
- Async reset mid-SHOW1, plus the macro build:
  - Async reset mid-SHOW1 drops outputs to inactive without waiting for clk.
  - With SEG7_LEADING_ZERO_BLANK_EN, value 05 leaves digit 1 dark; value 05 with dp_in=10 shows digit 1 as "0." (seg=3F, dp=1).
